// File: rtl/crack_par.sv
// Strided brute-force ARC4 key search core: drives an external arc4 engine and
// accepts the first key whose plaintext bytes are all printable ASCII.
module crack_par #(
    parameter int          KEY_W      = 24,
    parameter int unsigned KEY_START  = 0,
    parameter int unsigned KEY_STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic             abort,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic [7:0]       ct_addr,
    input  logic [7:0]       ct_rddata,
    output logic             arc4_en,
    input  logic             arc4_rdy,
    output logic [KEY_W-1:0] arc4_key,
    output logic [7:0]       pt_addr,
    input  logic [7:0]       pt_rddata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_SCAN    = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_FOUND   = 3'd6;
    localparam logic [2:0] S_EXHAUST = 3'd7;

    logic [2:0]       r_state;
    logic [KEY_W-1:0] r_cur_key;
    logic [KEY_W-1:0] r_key;
    logic             r_key_valid;
    logic [7:0]       r_len;
    logic [7:0]       r_pt_addr;
    logic             r_len_wait;
    logic             r_skip;
    logic             r_abort;
    logic             r_chk_valid;
    logic             r_chk_last;

    logic [KEY_W:0]   w_nxt;
    logic             w_byte_ok;
    logic             w_launch;

    // One extra bit catches stepping past the top of the keyspace; wrap is never taken.
    assign w_nxt     = {1'b0, r_cur_key} + (KEY_W+1)'(KEY_STRIDE);
    assign w_byte_ok = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);
    assign w_launch  = (r_state == S_START) && arc4_rdy && !abort;

    assign rdy       = (r_state == S_IDLE);
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign ct_addr   = 8'd0;
    assign arc4_en   = w_launch;
    assign arc4_key  = r_cur_key;
    assign pt_addr   = r_pt_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_key   <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_len       <= 8'd0;
            r_pt_addr   <= 8'd0;
            r_len_wait  <= 1'b0;
            r_skip      <= 1'b0;
            r_abort     <= 1'b0;
            r_chk_valid <= 1'b0;
            r_chk_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_cur_key   <= KEY_W'(KEY_START);
                        r_key_valid <= 1'b0;
                        r_len_wait  <= 1'b1;
                        r_state     <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_len_wait) begin
                        r_len_wait <= 1'b0;
                    end else begin
                        r_len   <= ct_rddata;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (arc4_rdy) begin
                        r_skip  <= 1'b1;
                        r_abort <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A running arc4 is never cut short; abort is remembered until it finishes.
                    r_skip <= 1'b0;
                    if (abort) begin
                        r_abort <= 1'b1;
                    end
                    if (!r_skip && arc4_rdy) begin
                        if (r_abort || abort) begin
                            r_state <= S_IDLE;
                        end else if (r_len == 8'd0) begin
                            r_state <= S_FOUND;
                        end else begin
                            r_pt_addr   <= 8'd1;
                            r_chk_valid <= 1'b0;
                            r_state     <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    // Address i is issued while byte i-1 (returned this cycle) is checked.
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_chk_valid && !w_byte_ok) begin
                        r_state <= S_NEXT;
                    end else if (r_chk_valid && r_chk_last) begin
                        r_state <= S_FOUND;
                    end else begin
                        r_chk_valid <= 1'b1;
                        r_chk_last  <= (r_pt_addr == r_len);
                        if (r_pt_addr != r_len) begin
                            r_pt_addr <= r_pt_addr + 8'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_nxt[KEY_W]) begin
                        r_state <= S_EXHAUST;
                    end else begin
                        r_cur_key <= w_nxt[KEY_W-1:0];
                        r_state   <= S_START;
                    end
                end
                S_FOUND: begin
                    r_key       <= r_cur_key;
                    r_key_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_EXHAUST: begin
                    r_key_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crack_par.sv
// Directed bench for crack_par: five cores share one clock/reset, each with its
// own behavioural arc4 engine and ciphertext/plaintext memories.
module tb_crack_par;

    logic clk;
    logic rst;

    logic        en_drv[5];
    logic        abort_drv[5];
    logic        rdy_w[5];
    logic [23:0] key_w[5];
    logic        kv_w[5];
    logic [7:0]  cta_w[5];
    logic        aen_w[5];
    logic [23:0] ak_w[5];
    logic [7:0]  pta_w[5];

    logic [7:0]  ct_rd[5];
    logic [7:0]  pt_rd[5];
    logic        e_rdy[5];
    int          e_cnt[5];
    logic [23:0] e_key[5];
    int          en_cnt[5] = '{default: 0};
    logic [23:0] last_key[5];
    int          nz_cnt[5] = '{default: 0};

    logic [7:0]  ct_mem[5][256];
    logic [24:0] good_key[5];
    int          run_len[5];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core 0: 24b/0/1, cores 1,2: 24b stride 2 (2 aborted by 1), core 3: 8b/0/1, core 4: 8b/0xFD/4.
    for (genvar gi = 0; gi < 5; gi++) begin : g_core
        localparam int unsigned ST = (gi == 2) ? 1 : (gi == 4) ? 32'hFD : 0;
        localparam int unsigned SD = (gi == 1 || gi == 2) ? 2 : (gi == 4) ? 4 : 1;
        logic w_abort;
        if (gi == 2) begin : g_ab
            assign w_abort = abort_drv[gi] | kv_w[1];
        end else begin : g_ab
            assign w_abort = abort_drv[gi];
        end
        if (gi < 3) begin : g_w24
            crack_par #(.KEY_W(24), .KEY_START(ST), .KEY_STRIDE(SD)) u_dut (
                .clk(clk), .rst(rst), .en(en_drv[gi]), .rdy(rdy_w[gi]), .abort(w_abort),
                .key(key_w[gi]), .key_valid(kv_w[gi]), .ct_addr(cta_w[gi]), .ct_rddata(ct_rd[gi]),
                .arc4_en(aen_w[gi]), .arc4_rdy(e_rdy[gi]), .arc4_key(ak_w[gi]),
                .pt_addr(pta_w[gi]), .pt_rddata(pt_rd[gi]));
        end else begin : g_w8
            logic [7:0] k8;
            logic [7:0] ak8;
            crack_par #(.KEY_W(8), .KEY_START(ST), .KEY_STRIDE(SD)) u_dut (
                .clk(clk), .rst(rst), .en(en_drv[gi]), .rdy(rdy_w[gi]), .abort(w_abort),
                .key(k8), .key_valid(kv_w[gi]), .ct_addr(cta_w[gi]), .ct_rddata(ct_rd[gi]),
                .arc4_en(aen_w[gi]), .arc4_rdy(e_rdy[gi]), .arc4_key(ak8),
                .pt_addr(pta_w[gi]), .pt_rddata(pt_rd[gi]));
            assign key_w[gi] = {16'd0, k8};
            assign ak_w[gi]  = {16'd0, ak8};
        end
    end

    // Engine model: right key yields ct unchanged; a wrong even key corrupts byte 1
    // (0x20 -> 0x1F), a wrong odd key corrupts byte L (0x7E -> 0x7F).
    function automatic logic [7:0] pt_model(input logic [7:0] c, input logic [7:0] a,
                                            input logic [7:0] len, input logic [23:0] k,
                                            input logic [24:0] good);
        logic [7:0] m;
        m = 8'h00;
        if (a != 8'd0 && {1'b0, k} != good) begin
            if (k[0]) m = (a == len) ? 8'h01 : 8'h00;
            else      m = (a == 8'd1) ? 8'h3F : 8'h00;
        end
        return c ^ m;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            ct_rd[i] <= ct_mem[i][cta_w[i]];
            pt_rd[i] <= pt_model(ct_mem[i][pta_w[i]], pta_w[i], ct_mem[i][0], e_key[i], good_key[i]);
            if (aen_w[i]) begin
                en_cnt[i]   <= en_cnt[i] + 1;
                last_key[i] <= ak_w[i];
            end
            if (pta_w[i] != 8'd0) nz_cnt[i] <= nz_cnt[i] + 1;
            if (rst) begin
                e_rdy[i] <= 1'b1;
                e_cnt[i] <= 0;
            end else if (e_rdy[i]) begin
                if (aen_w[i]) begin
                    e_rdy[i] <= 1'b0;
                    e_cnt[i] <= run_len[i];
                    e_key[i] <= ak_w[i];
                end
            end else if (e_cnt[i] == 0) begin
                e_rdy[i] <= 1'b1;
            end else begin
                e_cnt[i] <= e_cnt[i] - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic pulse_en(input int gi);
        @(negedge clk);
        en_drv[gi] = 1'b1;
        @(negedge clk);
        en_drv[gi] = 1'b0;
    endtask

    task automatic wait_rdy(input int gi, input int budget, input string tag);
        int n = 0;
        while (!rdy_w[gi] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rdy_w[gi]), 32'd1);
    endtask

    task automatic wait_erdy(input int gi, input logic val, input int budget, input string tag);
        int n = 0;
        while (e_rdy[gi] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(e_rdy[gi]), 32'(val));
    endtask

    int c0;
    int c1;
    int n0;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            en_drv[i]    = 1'b0;
            abort_drv[i] = 1'b0;
            run_len[i]   = 4;
            for (int a = 0; a < 256; a++) ct_mem[i][a] = 8'h00;
            ct_mem[i][0] = 8'd4;
            ct_mem[i][1] = 8'h20;
            ct_mem[i][2] = 8'h41;
            ct_mem[i][3] = 8'h5A;
            ct_mem[i][4] = 8'h7E;
            good_key[i]  = (i < 3) ? 25'h0000018 : 25'h1000000;
        end
        repeat (3) @(negedge clk);

        check("reset_rdy",       32'(rdy_w[0]), 32'd1);
        check("reset_key",       32'(key_w[0]), 32'd0);
        check("reset_key_valid", 32'(kv_w[0]),  32'd0);
        check("reset_arc4_en",   32'(aen_w[0]), 32'd0);
        check("reset_arc4_key",  32'(ak_w[0]),  32'd0);
        check("reset_ct_addr",   32'(cta_w[0]), 32'd0);
        check("reset_pt_addr",   32'(pta_w[0]), 32'd0);
        rst = 1'b0;

        // Single core finds 0x18 after 0x19 runs; a stray en mid-run is ignored.
        c0 = en_cnt[0];
        pulse_en(0);
        check("busy_rdy_low", 32'(rdy_w[0]), 32'd0);
        repeat (30) @(negedge clk);
        en_drv[0] = 1'b1;
        @(negedge clk);
        en_drv[0] = 1'b0;
        wait_rdy(0, 5000, "find_done");
        check("find_key",       32'(key_w[0]), 32'h18);
        check("find_key_valid", 32'(kv_w[0]), 32'd1);
        check("find_runs",      32'(en_cnt[0] - c0), 32'h19);
        c0 = en_cnt[0];
        repeat (20) @(negedge clk);
        check("find_no_more_runs", 32'(en_cnt[0] - c0), 32'd0);
        check("find_key_held",     32'(key_w[0]), 32'h18);

        // Even/odd pair: even core finds, odd core is aborted by its key_valid.
        c1 = en_cnt[1];
        @(negedge clk);
        en_drv[1] = 1'b1;
        en_drv[2] = 1'b1;
        @(negedge clk);
        en_drv[1] = 1'b0;
        en_drv[2] = 1'b0;
        wait_rdy(1, 5000, "even_done");
        check("even_key",       32'(key_w[1]), 32'h18);
        check("even_key_valid", 32'(kv_w[1]), 32'd1);
        check("even_runs",      32'(en_cnt[1] - c1), 32'd13);
        wait_rdy(2, 200, "odd_done");
        check("odd_key_valid",  32'(kv_w[2]), 32'd0);

        // 8-bit core with no decryptable key exhausts after 256 runs.
        c0 = en_cnt[3];
        pulse_en(3);
        wait_rdy(3, 20000, "exh_done");
        check("exh_runs",      32'(en_cnt[3] - c0), 32'd256);
        check("exh_last_key",  32'(last_key[3]), 32'hFF);
        check("exh_key_valid", 32'(kv_w[3]), 32'd0);
        check("exh_key",       32'(key_w[3]), 32'd0);

        // Start 0xFD stride 4: next key overflows, so exactly one run.
        c0 = en_cnt[4];
        pulse_en(4);
        wait_rdy(4, 500, "ovf_done");
        check("ovf_runs",      32'(en_cnt[4] - c0), 32'd1);
        check("ovf_last_key",  32'(last_key[4]), 32'hFD);
        check("ovf_key_valid", 32'(kv_w[4]), 32'd0);

        // Reset while scanning the first key.
        pulse_en(0);
        wait_erdy(0, 1'b0, 50, "scan_arc4_started");
        wait_erdy(0, 1'b1, 50, "scan_arc4_done");
        @(negedge clk);
        check("scan_pt_addr", 32'(pta_w[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rdy",       32'(rdy_w[0]), 32'd1);
        check("rst_key",       32'(key_w[0]), 32'd0);
        check("rst_key_valid", 32'(kv_w[0]), 32'd0);
        check("rst_arc4_en",   32'(aen_w[0]), 32'd0);
        rst = 1'b0;

        // Zero-length message: first key reported, no plaintext reads.
        ct_mem[0][0] = 8'd0;
        c0 = en_cnt[0];
        n0 = nz_cnt[0];
        pulse_en(0);
        wait_rdy(0, 200, "len0_done");
        check("len0_key",       32'(key_w[0]), 32'd0);
        check("len0_key_valid", 32'(kv_w[0]), 32'd1);
        check("len0_runs",      32'(en_cnt[0] - c0), 32'd1);
        check("len0_pt_reads",  32'(nz_cnt[0] - n0), 32'd0);
        ct_mem[0][0] = 8'd4;

        // Abort while arc4 busy: wait it out, then idle with no new launch.
        run_len[0] = 20;
        c0 = en_cnt[0];
        pulse_en(0);
        wait_erdy(0, 1'b0, 50, "abort_arc4_started");
        repeat (2) @(negedge clk);
        abort_drv[0] = 1'b1;
        @(negedge clk);
        abort_drv[0] = 1'b0;
        check("abort_rdy_held", 32'(rdy_w[0]), 32'd0);
        wait_rdy(0, 100, "abort_done");
        check("abort_after_arc4", 32'(e_rdy[0]), 32'd1);
        check("abort_key_valid",  32'(kv_w[0]), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_runs", 32'(en_cnt[0] - c0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
